qupls4_btb_stream_allocator: RTL and testbench

Parametrised per-thread PC-stream allocator for the Qupls4 fetch/BTB front end. It owns the stream-valid bitmap and the stream ancestry (dependency) matrix for every thread, picks free stream numbers internally, and frees streams two ways: singly on retire, or transitively on branch-mispredict flush (the stream plus all its descendants). It sits between the BTB/branch-predict logic, which requests new streams at predicted branches, and the commit/flush logic.

---
 rtl/qupls4_btb_stream_allocator_pkg.sv | 33 +++
 rtl/qupls4_stream_ffz.sv | 31 +++
 rtl/qupls4_btb_stream_allocator.sv | 178 +++++++++++++++++
 tb/tb_qupls4_btb_stream_allocator.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qupls4_btb_stream_allocator_pkg.sv
// Shared definitions for the Qupls4 BTB stream allocator.
//   THREADS / XSTREAMS : default hardware thread count and streams per thread.
//   stream_idx_t       : stream number within a thread.
//   thread_idx_t       : hardware thread number.
//   pc_stream_t        : fully qualified PC stream (thread + stream).
//   popcount64         : population count used to derive free-stream counts.
package qupls4_btb_stream_allocator_pkg;

   localparam int THREADS  = 4;
   localparam int XSTREAMS = 32;

   localparam int SW_DEF = $clog2(XSTREAMS);
   localparam int TW_DEF = (THREADS > 1) ? $clog2(THREADS) : 1;

   typedef logic [SW_DEF-1:0] stream_idx_t;
   typedef logic [TW_DEF-1:0] thread_idx_t;

   typedef struct packed {
      thread_idx_t thread;
      stream_idx_t stream;
   } pc_stream_t;

   // Widest supported stream bitmap is 64 bits; narrower callers zero-extend.
   function automatic logic [6:0] popcount64(input logic [63:0] v);
      logic [6:0] n;
      n = '0;
      for (int i = 0; i < 64; i++) begin
         n = n + {6'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/qupls4_stream_ffz.sv
// Find-first-zero over a stream bitmap.
//   busy  : live-stream bitmap.
//   mask  : streams that must not be picked even though they read as free.
//   idx   : lowest index that is zero in (busy | mask).
//   empty : no such index exists (idx is then 0).
module qupls4_stream_ffz #(
   parameter int WIDTH = 32,
   parameter int IW    = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] busy,
   input  logic [WIDTH-1:0] mask,
   output logic [IW-1:0]    idx,
   output logic             empty
);

   logic [WIDTH-1:0] taken;

   always_comb begin
      taken = busy | mask;
      idx   = '0;
      empty = 1'b1;
      // Scan downward so the last hit is the lowest free index.
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!taken[i]) begin
            idx   = IW'(i);
            empty = 1'b0;
         end
      end
   end

endmodule

// File: rtl/qupls4_btb_stream_allocator.sv
// Per-thread PC-stream allocator for the fetch/BTB front end.
// Owns the live-stream bitmap and the stream ancestry matrix of every thread.
//   clk, rst       : clock; asynchronous active-high reset.
//   clk_en         : global enable; low freezes all state except the response strobes.
//   alloc_*        : request a new stream spawned from alloc_parent on alloc_thread.
//   alloc_gnt/nack : registered one-cycle response; alloc_stream valid with alloc_gnt.
//   retire_*       : free a single stream.
//   flush_*        : free a stream and every descendant of it.
//   strm_bitmap    : live streams, bit t*XSTREAMS+s.
//   new_stream     : last stream granted per thread, field t*SW.
//   free_count     : free streams per thread, field t*(SW+1).
//   full           : thread has no free stream.
module qupls4_btb_stream_allocator #(
   parameter int THREADS  = qupls4_btb_stream_allocator_pkg::THREADS,
   parameter int XSTREAMS = qupls4_btb_stream_allocator_pkg::XSTREAMS,
   parameter int SW       = $clog2(XSTREAMS),
   parameter int TW       = (THREADS > 1) ? $clog2(THREADS) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clk_en,
   input  logic                     alloc_req,
   input  logic [TW-1:0]            alloc_thread,
   input  logic [SW-1:0]            alloc_parent,
   output logic                     alloc_gnt,
   output logic                     alloc_nack,
   output logic [SW-1:0]            alloc_stream,
   input  logic                     retire_valid,
   input  logic [TW-1:0]            retire_thread,
   input  logic [SW-1:0]            retire_stream,
   input  logic                     flush_valid,
   input  logic [TW-1:0]            flush_thread,
   input  logic [SW-1:0]            flush_stream,
   output logic [XSTREAMS*THREADS-1:0] strm_bitmap,
   output logic [THREADS*SW-1:0]    new_stream,
   output logic [THREADS*(SW+1)-1:0] free_count,
   output logic [THREADS-1:0]       full
);

   import qupls4_btb_stream_allocator_pkg::*;

   logic [XSTREAMS-1:0] bitmap_q [THREADS];
   logic [XSTREAMS-1:0] bitmap_d [THREADS];
   // dep_q[t][s] : ancestors of stream s (including s itself).
   logic [XSTREAMS-1:0] dep_q    [THREADS][XSTREAMS];
   logic [XSTREAMS-1:0] dep_d    [THREADS][XSTREAMS];
   logic [SW-1:0]       new_stream_q [THREADS];
   logic [SW-1:0]       new_stream_d [THREADS];
   logic [SW:0]         free_count_q [THREADS];
   logic [SW:0]         free_count_d [THREADS];

   logic [XSTREAMS-1:0] flush_set [THREADS];
   logic [XSTREAMS-1:0] kill      [THREADS];
   logic [SW-1:0]       ffz_idx   [THREADS];
   logic                ffz_empty [THREADS];

   logic                alloc_gnt_q, alloc_nack_q;
   logic [SW-1:0]       alloc_stream_q;

   logic                thread_ok;
   logic [SW-1:0]       sel_idx;
   logic                sel_empty;
   logic                parent_live;
   logic                parent_flushed;
   logic                grant;
   logic                nack;
   logic [XSTREAMS-1:0] win_onehot;
   logic [63:0]         pc_vec;

   // Streams freed this cycle. Stream 0 is the root and never freed.
   always_comb begin
      for (int t = 0; t < THREADS; t++) begin
         flush_set[t] = '0;
         if (clk_en && flush_valid && int'(flush_thread) == t) begin
            for (int d = 0; d < XSTREAMS; d++) begin
               flush_set[t][d] = dep_q[t][d][flush_stream];
            end
         end
         flush_set[t][0] = 1'b0;
         kill[t] = flush_set[t];
         if (clk_en && retire_valid && int'(retire_thread) == t) begin
            kill[t][retire_stream] = 1'b1;
         end
         kill[t][0] = 1'b0;
      end
   end

   // Streams being freed are masked so they cannot be reused in the same cycle.
   for (genvar g = 0; g < THREADS; g++) begin : g_ffz
      qupls4_stream_ffz #(
         .WIDTH (XSTREAMS)
      ) u_ffz (
         .busy  (bitmap_q[g]),
         .mask  (kill[g]),
         .idx   (ffz_idx[g]),
         .empty (ffz_empty[g])
      );
   end

   always_comb begin
      thread_ok      = int'(alloc_thread) < THREADS;
      sel_idx        = '0;
      sel_empty      = 1'b1;
      parent_live    = 1'b0;
      parent_flushed = 1'b0;
      if (thread_ok) begin
         sel_idx        = ffz_idx[alloc_thread];
         sel_empty      = ffz_empty[alloc_thread];
         parent_live    = bitmap_q[alloc_thread][alloc_parent];
         parent_flushed = flush_set[alloc_thread][alloc_parent];
      end
      grant = clk_en && alloc_req && thread_ok && !sel_empty && parent_live && !parent_flushed;
      nack  = clk_en && alloc_req && !grant;
      win_onehot          = '0;
      win_onehot[sel_idx] = 1'b1;
   end

   // Next state: clear freed rows/columns, then install the winner's row.
   always_comb begin
      pc_vec = '0;
      for (int t = 0; t < THREADS; t++) begin
         bitmap_d[t]     = bitmap_q[t] & ~kill[t];
         new_stream_d[t] = new_stream_q[t];
         for (int s = 0; s < XSTREAMS; s++) begin
            dep_d[t][s] = kill[t][s] ? '0 : (dep_q[t][s] & ~kill[t]);
         end
         if (grant && int'(alloc_thread) == t) begin
            bitmap_d[t][sel_idx] = 1'b1;
            dep_d[t][sel_idx]    = (dep_q[t][alloc_parent] | win_onehot) & ~kill[t];
            new_stream_d[t]      = sel_idx;
         end
         pc_vec                 = '0;
         pc_vec[XSTREAMS-1:0]   = bitmap_d[t];
         free_count_d[t]        = (SW + 1)'(XSTREAMS - int'(popcount64(pc_vec)));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int t = 0; t < THREADS; t++) begin
            bitmap_q[t]     <= XSTREAMS'(1);
            new_stream_q[t] <= '0;
            free_count_q[t] <= (SW + 1)'(XSTREAMS - 1);
            for (int s = 0; s < XSTREAMS; s++) begin
               dep_q[t][s] <= (s == 0) ? XSTREAMS'(1) : '0;
            end
         end
         alloc_gnt_q    <= 1'b0;
         alloc_nack_q   <= 1'b0;
         alloc_stream_q <= '0;
      end else begin
         // grant/nack already fold in clk_en, so the strobes fall when disabled.
         alloc_gnt_q  <= grant;
         alloc_nack_q <= nack;
         if (grant) begin
            alloc_stream_q <= sel_idx;
         end
         if (clk_en) begin
            bitmap_q     <= bitmap_d;
            dep_q        <= dep_d;
            new_stream_q <= new_stream_d;
            free_count_q <= free_count_d;
         end
      end
   end

   assign alloc_gnt    = alloc_gnt_q;
   assign alloc_nack   = alloc_nack_q;
   assign alloc_stream = alloc_stream_q;

   for (genvar g = 0; g < THREADS; g++) begin : g_out
      assign strm_bitmap[g*XSTREAMS +: XSTREAMS] = bitmap_q[g];
      assign new_stream[g*SW +: SW]              = new_stream_q[g];
      assign free_count[g*(SW+1) +: SW+1]        = free_count_q[g];
      assign full[g]                             = (free_count_q[g] == '0);
   end

endmodule

// File: tb/tb_qupls4_btb_stream_allocator.sv
// Scoreboard bench for qupls4_btb_stream_allocator (THREADS=4, XSTREAMS=32).
module tb_qupls4_btb_stream_allocator;

   localparam int T  = 4;
   localparam int X  = 32;
   localparam int SW = 5;
   localparam int TW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              clk_en;
   logic              alloc_req;
   logic [TW-1:0]     alloc_thread;
   logic [SW-1:0]     alloc_parent;
   logic              alloc_gnt;
   logic              alloc_nack;
   logic [SW-1:0]     alloc_stream;
   logic              retire_valid;
   logic [TW-1:0]     retire_thread;
   logic [SW-1:0]     retire_stream;
   logic              flush_valid;
   logic [TW-1:0]     flush_thread;
   logic [SW-1:0]     flush_stream;
   logic [X*T-1:0]    strm_bitmap;
   logic [T*SW-1:0]   new_stream;
   logic [T*(SW+1)-1:0] free_count;
   logic [T-1:0]      full;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic          gnt;
      logic [SW-1:0] stream;
   } exp_t;
   exp_t exp_q[$];

   qupls4_btb_stream_allocator #(
      .THREADS  (T),
      .XSTREAMS (X)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .clk_en        (clk_en),
      .alloc_req     (alloc_req),
      .alloc_thread  (alloc_thread),
      .alloc_parent  (alloc_parent),
      .alloc_gnt     (alloc_gnt),
      .alloc_nack    (alloc_nack),
      .alloc_stream  (alloc_stream),
      .retire_valid  (retire_valid),
      .retire_thread (retire_thread),
      .retire_stream (retire_stream),
      .flush_valid   (flush_valid),
      .flush_thread  (flush_thread),
      .flush_stream  (flush_stream),
      .strm_bitmap   (strm_bitmap),
      .new_stream    (new_stream),
      .free_count    (free_count),
      .full          (full)
   );

   always #5 clk = ~clk;

   // Monitor: every response strobe consumes one expectation.
   always @(negedge clk) begin
      if (!rst && (alloc_gnt || alloc_nack)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp: gnt=%0b nack=%0b stream=%0d, none expected",
                     alloc_gnt, alloc_nack, alloc_stream);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (alloc_gnt !== e.gnt || alloc_nack !== !e.gnt ||
                (e.gnt && alloc_stream !== e.stream)) begin
               errors++;
               $display("FAIL alloc_resp: got gnt=%0b nack=%0b stream=%0d, want gnt=%0b nack=%0b stream=%0d",
                        alloc_gnt, alloc_nack, alloc_stream, e.gnt, !e.gnt, e.stream);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   function automatic logic [X-1:0] bm(input int t);
      return strm_bitmap[t*X +: X];
   endfunction

   function automatic logic [SW:0] fc(input int t);
      return free_count[t*(SW+1) +: SW+1];
   endfunction

   function automatic logic [SW-1:0] ns(input int t);
      return new_stream[t*SW +: SW];
   endfunction

   // One-cycle alloc; leaves any retire/flush set up by the caller in place.
   task automatic do_alloc(input int th, input int par, input bit g, input int s);
      exp_t e;
      alloc_req    = 1'b1;
      alloc_thread = th[TW-1:0];
      alloc_parent = par[SW-1:0];
      e.gnt        = g;
      e.stream     = s[SW-1:0];
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      alloc_req = 1'b0;
   endtask

   task automatic do_retire(input int th, input int s);
      retire_valid  = 1'b1;
      retire_thread = th[TW-1:0];
      retire_stream = s[SW-1:0];
      @(posedge clk);
      #1;
      retire_valid = 1'b0;
   endtask

   task automatic do_flush(input int th, input int s);
      flush_valid  = 1'b1;
      flush_thread = th[TW-1:0];
      flush_stream = s[SW-1:0];
      @(posedge clk);
      #1;
      flush_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      clk_en = 1'b1;
      alloc_req = 1'b0; alloc_thread = '0; alloc_parent = '0;
      retire_valid = 1'b0; retire_thread = '0; retire_stream = '0;
      flush_valid = 1'b0; flush_thread = '0; flush_stream = '0;
      #2;
      chk("reset_bitmap", 128'(strm_bitmap), {4{32'h0000_0001}});
      chk("reset_new_stream", 128'(new_stream), 128'd0);
      chk("reset_free_count", 128'(free_count), {4{6'd31}});
      chk("reset_full", 128'(full), 128'd0);
      chk("reset_gnt_nack", {126'd0, alloc_gnt, alloc_nack}, 128'd0);
      #10;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Thread 1: three back-to-back allocs from root.
      do_alloc(1, 0, 1, 1);
      do_alloc(1, 0, 1, 2);
      do_alloc(1, 0, 1, 3);
      chk("t1_new_stream", 128'(ns(1)), 128'd3);
      chk("t1_free_count", 128'(fc(1)), 128'd28);
      chk("t1_bitmap", 128'(bm(1)), 128'h0F);

      // Thread 2: chain 1->2->3, flush 1 frees the whole chain.
      do_alloc(2, 0, 1, 1);
      do_alloc(2, 1, 1, 2);
      do_alloc(2, 2, 1, 3);
      chk("t2_chain_bitmap", 128'(bm(2)), 128'h0F);
      do_flush(2, 1);
      chk("t2_flush_bitmap", 128'(bm(2)), 128'h01);
      chk("t2_flush_free", 128'(fc(2)), 128'd31);
      chk("t1_untouched", 128'(bm(1)), 128'h0F);

      // Thread 3: flush 2 while allocating from its descendant 3.
      do_alloc(3, 0, 1, 1);
      do_alloc(3, 1, 1, 2);
      do_alloc(3, 2, 1, 3);
      flush_valid = 1'b1; flush_thread = 2'd3; flush_stream = 5'd2;
      do_alloc(3, 3, 0, 0);
      flush_valid = 1'b0;
      chk("t3_flush_alloc_bitmap", 128'(bm(3)), 128'h03);
      do_alloc(3, 1, 1, 2);
      chk("t3_reuse_bitmap", 128'(bm(3)), 128'h07);

      // Thread 1: retire 4 while allocating; 4 is not reused the same cycle.
      do_alloc(1, 0, 1, 4);
      do_alloc(1, 0, 1, 5);
      retire_valid = 1'b1; retire_thread = 2'd1; retire_stream = 5'd4;
      do_alloc(1, 0, 1, 6);
      retire_valid = 1'b0;
      chk("t1_retire_alloc_bitmap", 128'(bm(1)), 128'h6F);
      do_alloc(1, 0, 1, 4);
      chk("t1_regrant_bitmap", 128'(bm(1)), 128'h7F);
      chk("t1_regrant_new_stream", 128'(ns(1)), 128'd4);
      do_flush(1, 0);
      chk("t1_flush_root", 128'(bm(1)), 128'h01);

      // Thread 0: fill, overflow, retire 5, regrant 5.
      for (int i = 1; i < X; i++) begin
         do_alloc(0, 0, 1, i);
      end
      do_alloc(0, 0, 0, 0);
      chk("t0_full", 128'(full[0]), 128'd1);
      chk("t0_free_zero", 128'(fc(0)), 128'd0);
      do_retire(0, 5);
      chk("t0_after_retire_free", 128'(fc(0)), 128'd1);
      chk("t0_after_retire_full", 128'(full[0]), 128'd0);
      do_alloc(0, 0, 1, 5);
      chk("t0_refull", 128'(full[0]), 128'd1);
      do_retire(0, 0);
      chk("t0_root_retire", 128'(bm(0)), 128'hFFFF_FFFF);
      do_retire(2, 9);
      chk("t2_retire_free_noop", 128'(bm(2)), 128'h01);

      // Non-live parent is refused.
      do_alloc(2, 7, 0, 0);
      chk("t2_nack_bitmap", 128'(bm(2)), 128'h01);

      // clk_en low: nothing moves, no response strobe.
      clk_en = 1'b0;
      alloc_req = 1'b1; alloc_thread = 2'd2; alloc_parent = 5'd0;
      flush_valid = 1'b1; flush_thread = 2'd0; flush_stream = 5'd0;
      @(posedge clk);
      #1;
      alloc_req = 1'b0; flush_valid = 1'b0;
      clk_en = 1'b1;
      chk("clk_en_gnt", {126'd0, alloc_gnt, alloc_nack}, 128'd0);
      chk("clk_en_t0_hold", 128'(bm(0)), 128'hFFFF_FFFF);
      chk("clk_en_t2_hold", 128'(bm(2)), 128'h01);

      // Reset arriving while a grant is showing clears it without a clock.
      @(negedge clk);
      alloc_req = 1'b1; alloc_thread = 2'd2; alloc_parent = 5'd0;
      @(posedge clk);
      #1;
      alloc_req = 1'b0;
      chk("pre_rst_gnt", {123'd0, alloc_gnt, alloc_stream}, {123'd0, 1'b1, 5'd1});
      rst = 1'b1;
      #1;
      chk("async_rst_gnt", 128'(alloc_gnt), 128'd0);
      chk("async_rst_bitmap", 128'(strm_bitmap), {4{32'h0000_0001}});
      chk("async_rst_free", 128'(free_count), {4{6'd31}});
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_resp: %0d expected responses never seen, want 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
